// File: rtl/ag_pattern_gen_if.sv
// Data-beat bus between ag_pattern_gen (master) and the eMMC data-path driver (slave).
// valid_o/data_o/wr_enbl_o are held stable until ready_i accepts the word.
interface ag_pattern_gen_if #(
    parameter int WIDTH = 8
) ();
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             wr_enbl_o;

    modport master (
        output valid_o,
        output data_o,
        output wr_enbl_o,
        input  ready_i
    );

    modport slave (
        input  valid_o,
        input  data_o,
        input  wr_enbl_o,
        output ready_i
    );
endinterface

// File: rtl/ag_pattern_gen.sv
// Test-data generator: alternating write/read-back parts, zero-latency valid/ready, words held while stalled.
// Optional 32-bit LFSR pattern for mode 3 enabled by macro AG_PATTERN_GEN_LFSR_EN (else mode 3 = checkerboard).
module ag_pattern_gen #(
    parameter int WIDTH         = 8,
    parameter int LENGTH        = 512,
    parameter int PARTS         = 4,
    parameter int INVERT_VALUES = 0
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    start_i,
    input  logic [1:0]              mode_i,
    ag_pattern_gen_if.master        bus,
    output logic                    started_part_o,
    output logic                    started_all_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int WW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int PW = $clog2(PARTS + 1);
    localparam logic [WIDTH-1:0] BASE =
        WIDTH'((INVERT_VALUES != 0) ? 32'h5555_5555 : 32'hAAAA_AAAA);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [PW-1:0]   part_q, part_d;
    logic [1:0]      mode_q, mode_d;

    logic            valid_c;
    logic            beat;
    logic            last_word;
    logic [PW-1:0]   pair_k;
    logic [31:0]     rot_c;
    logic [WIDTH-1:0] data_c;

`ifdef AG_PATTERN_GEN_LFSR_EN
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;

    logic [31:0] lfsr_q, lfsr_d, lfsr_cur;

    // Word 0 always sees the freshly seeded value, so a read-back part replays its write part.
    always_comb begin
        lfsr_cur = (word_q == '0) ? (LFSR_SEED ^ 32'(pair_k)) : lfsr_q;
        lfsr_d   = lfsr_q;
        if (beat) begin
            lfsr_d = {lfsr_cur[30:0], 1'b0} ^ (lfsr_cur[31] ? LFSR_TAPS : 32'h0);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign valid_c   = (state_q == S_RUN);
    assign beat      = valid_c && bus.ready_i;
    assign last_word = (word_q == WW'(LENGTH - 1));

    always_comb begin
        pair_k = part_q >> 1;
        rot_c  = (32'(word_q) + 32'(pair_k)) % 32'(WIDTH);
        case (mode_q)
            2'd1:    data_c = WIDTH'(1) << rot_c;
            2'd2:    data_c = WIDTH'(word_q) ^ {WIDTH{pair_k[0]}};
`ifdef AG_PATTERN_GEN_LFSR_EN
            2'd3:    data_c = lfsr_cur[WIDTH-1:0];
`endif
            default: data_c = BASE ^ {WIDTH{word_q[0] ^ pair_k[0]}};
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        part_d  = part_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    mode_d  = mode_i;
                    word_d  = '0;
                    part_d  = '0;
                end
            end
            S_RUN: begin
                if (beat) begin
                    if (last_word) begin
                        word_d = '0;
                        part_d = part_q + PW'(1);
                        if (part_q == PW'(PARTS - 1)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        word_d = word_q + WW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            part_q  <= '0;
            mode_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            part_q  <= part_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.valid_o     = valid_c;
    assign bus.data_o      = data_c;
    assign bus.wr_enbl_o   = ~part_q[0];
    assign started_part_o  = beat && (word_q == '0);
    assign started_all_o   = started_part_o && (part_q == '0);
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);

endmodule

// File: tb/tb_ag_pattern_gen.sv
// Randomised bench for ag_pattern_gen: per-run expected word table from the pattern formulas, random stalls/starts/reset.
module tb_ag_pattern_gen;

    localparam int WIDTH  = 8;
    localparam int LENGTH = 10;
    localparam int PARTS  = 4;
    localparam int TOTAL  = LENGTH * PARTS;

    logic       clk_i = 1'b0;
    logic       arst_i;
    logic       start_i;
    logic [1:0] mode_i;
    logic       started_part_o;
    logic       started_all_o;
    logic       busy_o;
    logic       done_o;

    int n_chk  = 0;
    int n_fail = 0;

    ag_pattern_gen_if #(.WIDTH(WIDTH)) ag_if ();

    ag_pattern_gen #(
        .WIDTH         (WIDTH),
        .LENGTH        (LENGTH),
        .PARTS         (PARTS),
        .INVERT_VALUES (0)
    ) u_dut (
        .clk_i          (clk_i),
        .arst_i         (arst_i),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .bus            (ag_if),
        .started_part_o (started_part_o),
        .started_all_o  (started_all_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected word w of part p, straight from the pattern definitions.
    function automatic logic [7:0] exp_data(input logic [1:0] m, input int p, input int w);
        int k;
        logic [32:0] v;
        k = p / 2;
        v = '0;
        case (m)
            2'd1: return 8'(1 << ((w + k) % WIDTH));
            2'd2: return 8'(w) ^ (((k % 2) == 1) ? 8'hFF : 8'h00);
`ifdef AG_PATTERN_GEN_LFSR_EN
            2'd3: begin
                // seed * x^w modulo x^32+x^22+x^2+x+1
                v = {1'b0, 32'hACE1_0001 ^ 32'(k)};
                repeat (w) begin
                    v = v << 1;
                    if (v[32]) v = v ^ 33'h1_0040_0007;
                end
                return v[7:0];
            end
`endif
            default: return (((w + k) % 2) == 1) ? 8'h55 : 8'hAA;
        endcase
    endfunction

    task automatic do_run(input logic [1:0] m, input int rdy_pct, input int rst_at);
        int  idx;
        bit  fin;
        bit  rdy;
        @(negedge clk_i);
        start_i       = 1'b1;
        mode_i        = m;
        ag_if.ready_i = 1'b0;
        #1;
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_vld", 32'(ag_if.valid_o), 0);
        @(negedge clk_i);
        idx = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            if (idx < TOTAL) begin
                rdy           = ($urandom_range(99) < rdy_pct);
                ag_if.ready_i = rdy;
                start_i       = 1'($urandom_range(1));
                mode_i        = 2'($urandom_range(3));
                #1;
                chk("run_vld",  32'(ag_if.valid_o), 1);
                chk("run_busy", 32'(busy_o), 1);
                chk("run_done", 32'(done_o), 0);
                chk("run_data", 32'(ag_if.data_o), 32'(exp_data(m, idx / LENGTH, idx % LENGTH)));
                chk("run_wr",   32'(ag_if.wr_enbl_o), 32'(((idx / LENGTH) % 2) == 0));
                chk("st_part",  32'(started_part_o), 32'(rdy && (idx % LENGTH) == 0));
                chk("st_all",   32'(started_all_o), 32'(rdy && idx == 0));
                if (idx == rst_at) begin
                    arst_i  = 1'b1;
                    start_i = 1'b0;
                    #1;
                    chk("rst_vld",  32'(ag_if.valid_o), 0);
                    chk("rst_busy", 32'(busy_o), 0);
                    chk("rst_done", 32'(done_o), 0);
                    chk("rst_wr",   32'(ag_if.wr_enbl_o), 1);
                    chk("rst_data", 32'(ag_if.data_o), 32'h0AA);
                    @(negedge clk_i);
                    arst_i = 1'b0;
                    #1;
                    chk("post_rst_done", 32'(done_o), 0);
                    chk("post_rst_busy", 32'(busy_o), 0);
                    fin = 1'b1;
                end else if (rdy) begin
                    idx++;
                end
            end else begin
                start_i       = 1'b1;
                ag_if.ready_i = 1'($urandom_range(1));
                #1;
                chk("done_pulse", 32'(done_o), 1);
                chk("done_vld",   32'(ag_if.valid_o), 0);
                chk("done_busy",  32'(busy_o), 1);
                chk("done_stp",   32'(started_part_o), 0);
                @(negedge clk_i);
                start_i = 1'b0;
                #1;
                chk("after_done", 32'(done_o), 0);
                chk("after_busy", 32'(busy_o), 0);
                chk("after_vld",  32'(ag_if.valid_o), 0);
                fin = 1'b1;
            end
            if (!fin) @(negedge clk_i);
        end
        if (!fin) chk("run_timeout", 1, 0);
    endtask

    initial begin
        arst_i        = 1'b1;
        start_i       = 1'b0;
        mode_i        = 2'd0;
        ag_if.ready_i = 1'b0;
        #3;
        chk("reset_vld",  32'(ag_if.valid_o), 0);
        chk("reset_done", 32'(done_o), 0);
        chk("reset_busy", 32'(busy_o), 0);
        chk("reset_stp",  32'(started_part_o), 0);
        chk("reset_sta",  32'(started_all_o), 0);
        chk("reset_wr",   32'(ag_if.wr_enbl_o), 1);
        chk("reset_data", 32'(ag_if.data_o), 32'h0AA);
        @(negedge clk_i);
        arst_i = 1'b0;

        do_run(2'd0, 100, -1);
        do_run(2'd1, 100, -1);
        do_run(2'd2, 60, -1);
        do_run(2'd3, 100, -1);
        do_run(2'd3, 50, -1);
        do_run(2'd0, 40, -1);
        do_run(2'd1, 100, 6);
        do_run(2'd0, 100, -1);
        do_run(2'd2, 70, 13);
        for (int i = 0; i < 6; i++) begin
            do_run(2'($urandom_range(3)), 30 + $urandom_range(70), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
